// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data (LSB first), 1 even-parity, 1 stop bit, mid-bit sampling.
// Optional build macro UART_RX_PARITY_CHECK_EN enables parity checking; otherwise o_parity_err is 0.
`timescale 1ns/1ps
module uart_rx #(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 9600,
  parameter int SYNC_STAGES      = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int CYCLES_PER_BAUD = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_BAUD       = CYCLES_PER_BAUD / 2;
  localparam int CNT_W           = ($clog2(CYCLES_PER_BAUD) > 14) ? $clog2(CYCLES_PER_BAUD) : 14;
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CYCLES_PER_BAUD - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BAUD - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_prev_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [2:0]             bit_q;
  logic [7:0]             shift_q;
  logic [7:0]             data_q;
  logic                   valid_q;
  logic                   ferr_q;
  logic                   busy_q;
  logic                   rx_s;
  logic                   start_edge;
  logic                   bit_tick;

  assign rx_s       = sync_q[SYNC_STAGES-1];
  assign start_edge = (state_q == IDLE) && rx_prev_q && !rx_s;
  assign bit_tick   = (cnt_q == FULL_LAST);

  // Synchroniser and edge history idle high so reset never looks like a start bit.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], i_rx};
      rx_prev_q <= rx_s;
    end
  end

  // Data bits arrive LSB first, so shifting right leaves bit 0 in place after 8 samples.
  always_ff @(posedge i_clk) begin
    if (state_q == DATA && bit_tick) begin
      shift_q <= {rx_s, shift_q[7:1]};
    end
  end

`ifdef UART_RX_PARITY_CHECK_EN
  logic perr_pend_q;
  logic perr_q;

  function automatic logic parity_bad(input logic p, input logic [7:0] d);
    return p ^ (^d);
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      perr_pend_q <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      if (state_q == PARITY && bit_tick) begin
        perr_pend_q <= parity_bad(rx_s, shift_q);
      end
      if (state_q == STOP && bit_tick) begin
        perr_q <= perr_pend_q;
      end
    end
  end

  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (start_edge) begin
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            bit_q <= '0;
            // A line back high at the start-bit centre was only a glitch.
            if (rx_s) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_tick) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= PARITY;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (bit_tick) begin
            cnt_q   <= '0;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (bit_tick) begin
            // Leaving at mid-stop lets a following start bit be caught with no idle gap.
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            data_q  <= shift_q;
            ferr_q  <= ~rx_s;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random frames against a reference model.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int CLK_F = 1_600_000;
  localparam int BAUD  = 100_000;
  localparam int CPB   = CLK_F / BAUD;
  localparam int HALF  = CPB / 2;
  localparam int SYNC  = 2;
  localparam int LAT   = SYNC + 2 + HALF + 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] o_data;
  logic       o_valid, o_parity_err, o_frame_err, o_busy;

  int total = 0;
  int bad = 0;

  uart_rx #(.INPUT_CLOCK_FREQ(CLK_F), .BAUD_RATE(BAUD), .SYNC_STAGES(SYNC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx), .o_data(o_data), .o_valid(o_valid),
    .o_parity_err(o_parity_err), .o_frame_err(o_frame_err), .o_busy(o_busy));

  always #5 clk = ~clk;

  // Monitor: collect every valid pulse as {data, parity_err, frame_err}.
  logic [9:0]  got_q[$];
  int unsigned cyc = 0;
  int unsigned last_vld_cyc = 0;
  int unsigned busy_cyc = 0;
  int unsigned dbl = 0;
  logic        prev_vld = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_valid) begin
      got_q.push_back({o_data, o_parity_err, o_frame_err});
      last_vld_cyc = cyc;
    end
    if (o_valid && prev_vld) dbl++;
    prev_vld = o_valid;
    if (o_busy) busy_cyc++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: even parity means data ones plus parity bit is an even count.
  function automatic logic [9:0] model(input logic [7:0] d, input logic p, input logic s);
    logic pe;
`ifdef UART_RX_PARITY_CHECK_EN
    pe = (($countones(d) + int'(p)) % 2) != 0;
`else
    pe = 1'b0;
`endif
    return {d, pe, ~s};
  endfunction

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  task automatic expect_frame(input string tag, input logic [9:0] e);
    logic [9:0] g;
    int w = 0;
    while (got_q.size() == 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_present"}, (got_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      chk({tag, "_data"}, {24'd0, g[9:2]}, {24'd0, e[9:2]});
      chk({tag, "_perr"}, {31'd0, g[1]}, {31'd0, e[1]});
      chk({tag, "_ferr"}, {31'd0, g[0]}, {31'd0, e[0]});
    end
  endtask

  initial begin
    logic [9:0]  exp_q[$];
    logic [9:0]  g;
    logic [7:0]  d;
    logic        p, s;
    int unsigned c0, b0, lat, bc, gap;

    rst_n = 1'b0;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_data",  {24'd0, o_data}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_perr",  {31'd0, o_parity_err}, 32'd0);
    chk("rst_ferr",  {31'd0, o_frame_err}, 32'd0);
    chk("rst_busy",  {31'd0, o_busy}, 32'd0);
    rst_n = 1'b1;
    idle(20);

    // Clean frame, latency from falling edge to valid
    c0 = cyc;
    send_frame(8'hA5, 1'b0, 1'b1);
    expect_frame("t1", model(8'hA5, 1'b0, 1'b1));
    lat = last_vld_cyc - c0;
    chk("t1_latency", (lat >= LAT - 1 && lat <= LAT + 1) ? 32'd1 : 32'd0, 32'd1);
    chk("t1_busy_after", {31'd0, o_busy}, 32'd0);
    idle(10);

    // Start-bit glitch
    b0 = busy_cyc;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(40);
    bc = busy_cyc - b0;
    chk("t2_busy_seen", (bc > 0 && bc <= HALF + 4) ? 32'd1 : 32'd0, 32'd1);
    chk("t2_no_valid", got_q.size(), 32'd0);
    chk("t2_busy_low", {31'd0, o_busy}, 32'd0);

    // Wrong parity
    send_frame(8'h01, 1'b0, 1'b1);
    idle(4);
    expect_frame("t3", model(8'h01, 1'b0, 1'b1));

    // Stop bit low followed by a long break: exactly one frame
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (39 * CPB) @(negedge clk);
    expect_frame("t4", model(8'h3C, 1'b0, 1'b0));
    chk("t4_no_second", got_q.size(), 32'd0);
    idle(32);
    chk("t4_still_none", got_q.size(), 32'd0);
    send_frame(8'h3C, 1'b0, 1'b1);
    idle(4);
    expect_frame("t4b", model(8'h3C, 1'b0, 1'b1));

    // Back-to-back frames with no idle bits
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle(4);
    expect_frame("t5a", model(8'h00, 1'b0, 1'b1));
    expect_frame("t5b", model(8'hFF, 1'b0, 1'b1));

    // Reset during data bit 4 aborts the frame
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rx = 1'b1;
    repeat (HALF) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_rst_data",  {24'd0, o_data}, 32'd0);
    chk("t6_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("t6_rst_perr",  {31'd0, o_parity_err}, 32'd0);
    chk("t6_rst_ferr",  {31'd0, o_frame_err}, 32'd0);
    chk("t6_rst_busy",  {31'd0, o_busy}, 32'd0);
    idle(12 * CPB);
    chk("t6_no_valid", got_q.size(), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(4);
    expect_frame("t6", model(8'h5A, 1'b0, 1'b1));

    // Random frames with random parity/stop errors and gaps
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      p = ($urandom_range(0, 3) == 0) ? ~(^d) : ^d;
      s = ($urandom_range(0, 4) != 0);
      send_frame(d, p, s);
      exp_q.push_back(model(d, p, s));
      gap = $urandom_range(0, 20);
      if (!s && gap < 2) gap = 2;
      idle(int'(gap));
    end
    idle(20);
    chk("rand_count", got_q.size(), exp_q.size());
    for (int n = 0; n < 24; n++) begin
      if (got_q.size() > 0 && exp_q.size() > 0) begin
        g = got_q.pop_front();
        chk($sformatf("rand%0d", n), {22'd0, g}, {22'd0, exp_q.pop_front()});
      end
    end

    chk("valid_single_cycle", dbl, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
